// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the asynchronous instruction ROM and buffers
// fetched words in a small FIFO handed to decode over VALID/READY.
module instr_fetch_unit #(
    parameter int          TAM_POSICIONES = 1024,
    parameter int          TAM_PALABRA    = 32,
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          DEPTH          = 2
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              STALL,
    input  logic                              REDIRECT,
    input  logic [31:0]                       REDIRECT_PC,
    output logic [$clog2(TAM_POSICIONES)-1:0] INS_ADDRESS,
    output logic                              READ_EN,
    input  logic [TAM_PALABRA-1:0]            INSTRUCTION_IN,
    output logic                              OUT_VALID,
    input  logic                              OUT_READY,
    output logic [TAM_PALABRA-1:0]            OUT_INSTR,
    output logic [31:0]                       OUT_PC,
    output logic                              MISALIGN
);
    localparam int AW = $clog2(TAM_POSICIONES);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [31:0]          pc_q, pc_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 misalign_q, misalign_d;
    logic [TAM_PALABRA-1:0] out_instr_q, out_instr_d;
    logic [31:0]          out_pc_q, out_pc_d;
    logic [TAM_PALABRA-1:0] mem_instr_q [DEPTH];
    logic [TAM_PALABRA-1:0] mem_instr_d [DEPTH];
    logic [31:0]          mem_pc_q [DEPTH];
    logic [31:0]          mem_pc_d [DEPTH];

    logic pop;
    logic fire;

    assign OUT_VALID   = (count_q != '0);
    assign pop         = OUT_VALID & OUT_READY;
    // Reset gates the fetch so the ROM sees no read while the stage is held.
    assign fire        = ~RESET & ~REDIRECT & ~STALL & ((count_q < DEPTH_C) | pop);
    assign READ_EN     = fire;
    assign INS_ADDRESS = pc_q[AW+1:2];
    assign OUT_INSTR   = out_instr_q;
    assign OUT_PC      = out_pc_q;
    assign MISALIGN    = misalign_q;

    always_comb begin
        pc_d        = pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        misalign_d  = 1'b0;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        mem_instr_d = mem_instr_q;
        mem_pc_d    = mem_pc_q;

        if (REDIRECT) begin
            pc_d       = {REDIRECT_PC[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            misalign_d = |REDIRECT_PC[1:0];
        end else begin
            if (fire) begin
                mem_instr_d[wr_ptr_q] = INSTRUCTION_IN;
                mem_pc_d[wr_ptr_q]    = pc_q;
                pc_d                  = pc_q + 32'd4;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end
            rd_ptr_d = rd_ptr_q + PW'(pop);
            count_d  = count_q + CW'(fire) - CW'(pop);
            // Head registers track the next head; the word being pushed right now
            // becomes the head when nothing older remains.
            if (count_d != '0) begin
                if (fire && (rd_ptr_d == wr_ptr_q)) begin
                    out_instr_d = INSTRUCTION_IN;
                    out_pc_d    = pc_q;
                end else begin
                    out_instr_d = mem_instr_q[rd_ptr_d];
                    out_pc_d    = mem_pc_q[rd_ptr_d];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q        <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            misalign_q  <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_pc_q[i]    <= '0;
            end
        end else begin
            pc_q        <= pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            misalign_q  <= misalign_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            mem_instr_q <= mem_instr_d;
            mem_pc_q    <= mem_pc_d;
        end
    end
endmodule
